operand_stack: RTL and testbench

//  Hardware operand stack for the stack-based CPU datapath; the producer and consumer side of the ALU.

---
 rtl/operand_stack.sv | 139 +++++++++++++
 tb/tb_operand_stack.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// Purpose: operand stack feeding a combinational ALU; executes NOP/PUSH/POP/BINOP/UNOP, one command per cycle.
// Latency: commands commit at the rising clk edge; tos/alu_a/alu_b/count read combinationally (0-cycle read).
// Backpressure: none; the controller checks full/empty/count, and an illegal command is dropped and flagged on err/err_code.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   cmd               0=NOP 1=PUSH 2=POP 3=BINOP 4=UNOP (5..7 act as NOP)
//   push_data         word stored on PUSH
//   alu_result        combinational ALU result, captured on BINOP/UNOP
//   alu_a / alu_b     next-of-top / top-of-stack (0 when that entry is absent)
//   tos               same value as alu_b
//   count/empty/full  occupancy
//   err / err_code    1-cycle illegal-command pulse / sticky code (1=overflow, 2=underflow)
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] CMD_PUSH  = 3'd1;
  localparam logic [2:0] CMD_POP   = 3'd2;
  localparam logic [2:0] CMD_BINOP = 3'd3;
  localparam logic [2:0] CMD_UNOP  = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  // Entry indices derived from the occupancy count. They wrap when the
  // count is too small (or at DEPTH for the push slot), but every use
  // below is guarded by the matching occupancy test.
  logic [AW-1:0] push_idx, tos_idx, nos_idx;
  logic          has_one, has_two, is_full;

  assign push_idx = AW'(count_q);
  assign tos_idx  = AW'(count_q - CW'(1));
  assign nos_idx  = AW'(count_q - CW'(2));

  assign has_one  = (count_q >= CW'(1));
  assign has_two  = (count_q >= CW'(2));
  assign is_full  = (count_q == CW'(DEPTH));

  // Operand presentation is purely combinational from state.
  assign alu_b    = has_one ? mem_q[tos_idx] : '0;
  assign alu_a    = has_two ? mem_q[nos_idx] : '0;
  assign tos      = alu_b;
  assign count    = count_q;
  assign empty    = !has_one;
  assign full     = is_full;
  assign err      = err_q;
  assign err_code = err_code_q;

  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;   // NOP-class commands keep the last code

    case (cmd)
      CMD_PUSH: begin
        if (!is_full) begin
          mem_d[push_idx] = push_data;
          count_d         = count_q + CW'(1);
          err_code_d      = ERR_NONE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
        end
      end
      CMD_POP: begin
        if (has_one) begin
          count_d    = count_q - CW'(1);
          err_code_d = ERR_NONE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
        end
      end
      CMD_BINOP: begin
        // Result overwrites NOS and the old TOS slot is abandoned; legal when full.
        if (has_two) begin
          mem_d[nos_idx] = alu_result;
          count_d        = count_q - CW'(1);
          err_code_d     = ERR_NONE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
        end
      end
      CMD_UNOP: begin
        if (has_one) begin
          mem_d[tos_idx] = alu_result;
          err_code_d     = ERR_NONE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       cmd = 3'd0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, tos;
  logic [CW-1:0]    count;
  logic             empty, full, err;
  logic [1:0]       err_code;

  int errors = 0;
  int checks = 0;

  // ALU stand-in: 0=ADD 1=SUB (A-B) 2=NOT B
  int alu_mode = 0;

  typedef struct packed {
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic             full;
    logic             empty;
    logic             err;
    logic [1:0]       code;
  } obs_t;

  obs_t             sb[$];
  logic [WIDTH-1:0] m_stk[$];
  logic [1:0]       m_code = 2'd0;
  logic             m_err = 1'b0;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .push_data(push_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .tos(tos),
    .count(count), .empty(empty), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input int mode, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (mode)
      0:       return a + b;
      1:       return a - b;
      default: return ~b;
    endcase
  endfunction

  always_comb begin
    alu_result = '0;
    alu_result = alu_f(alu_mode, alu_a, alu_b);
  end

  function automatic obs_t observe();
    return {count, tos, alu_a, full, empty, err, err_code};
  endfunction

  // Advance the reference model, queue the expected outcome, then apply the command for one edge.
  task automatic drive(input logic [2:0] c, input logic [WIDTH-1:0] d);
    obs_t e;
    int n;
    logic [WIDTH-1:0] a, b;
    n = m_stk.size();
    a = (n >= 2) ? m_stk[n-2] : '0;
    b = (n >= 1) ? m_stk[n-1] : '0;
    m_err = 1'b0;
    case (c)
      3'd1: if (n < DEPTH) begin m_stk.push_back(d); m_code = 2'd0; end
            else begin m_err = 1'b1; m_code = 2'd1; end
      3'd2: if (n >= 1) begin void'(m_stk.pop_back()); m_code = 2'd0; end
            else begin m_err = 1'b1; m_code = 2'd2; end
      3'd3: if (n >= 2) begin
              void'(m_stk.pop_back()); void'(m_stk.pop_back());
              m_stk.push_back(alu_f(alu_mode, a, b)); m_code = 2'd0;
            end else begin m_err = 1'b1; m_code = 2'd2; end
      3'd4: if (n >= 1) begin
              void'(m_stk.pop_back());
              m_stk.push_back(alu_f(alu_mode, a, b)); m_code = 2'd0;
            end else begin m_err = 1'b1; m_code = 2'd2; end
      default: ;
    endcase
    n = m_stk.size();
    e.count = CW'(n);
    e.tos   = (n >= 1) ? m_stk[n-1] : '0;
    e.nos   = (n >= 2) ? m_stk[n-2] : '0;
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.err   = m_err;
    e.code  = m_code;
    sb.push_back(e);
    cmd = c;
    push_data = d;
    @(posedge clk);
    #1;
    cmd = 3'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_stk.delete();
    m_err = 1'b0;
    m_code = 2'd0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    do_reset();
    o = observe();
    checks++;
    if (o !== obs_t'{4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_initial obs=%h exp=%h", o, obs_t'{4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0});
    end
    drive(3'd2, 8'h00);
    drive(3'd1, 8'h11);
    drive(3'd1, 8'h22);
    drive(3'd1, 8'h33);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (sb.size() == 0) begin
        o = observe();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_prefill obs=%h exp=%h", o, e); end
      end
    end
    // Assert reset mid-cycle, well clear of any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, tos, alu_a, err, err_code} !== {4'd0, 1'b1, 8'h00, 8'h00, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_async count=%0d empty=%b tos=%h alu_a=%h err=%b code=%0d exp 0/1/00/00/0/0",
                         count, empty, tos, alu_a, err, err_code);
    end
    do_reset();
  endtask

  task automatic test_binop_sub();
    obs_t o, e;
    do_reset();
    alu_mode = 1;
    drive(3'd1, 8'h05);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL sub_push1 obs=%h exp=%h", o, e); end
    drive(3'd1, 8'h03);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL sub_push2 obs=%h exp=%h", o, e); end
    checks++;
    if ({count, alu_a, alu_b} !== {4'd2, 8'h05, 8'h03}) begin
      errors++; $display("FAIL sub_operands count=%0d a=%h b=%h exp 2/05/03", count, alu_a, alu_b);
    end
    drive(3'd3, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || tos !== 8'h02 || count !== 4'd1) begin
      errors++; $display("FAIL sub_binop obs=%h exp=%h (tos=%h exp 02)", o, e, tos);
    end
  endtask

  task automatic test_overflow();
    obs_t o, e;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(3'd1, 8'(i));
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL ovf_fill%0d obs=%h exp=%h", i, o, e); end
    end
    checks++;
    if ({full, tos} !== {1'b1, 8'h08}) begin errors++; $display("FAIL ovf_full full=%b tos=%h exp 1/08", full, tos); end
    drive(3'd1, 8'h09);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {err, err_code, tos, count} !== {1'b1, 2'd1, 8'h08, 4'd8}) begin
      errors++; $display("FAIL ovf_push9 obs=%h exp=%h", o, e);
    end
    drive(3'd0, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {err, err_code} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL ovf_pulse_end obs=%h exp=%h", o, e);
    end
  endtask

  task automatic test_underflow();
    obs_t o, e;
    do_reset();
    drive(3'd2, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {err, err_code, count} !== {1'b1, 2'd2, 4'd0}) begin
      errors++; $display("FAIL unf_pop obs=%h exp=%h", o, e);
    end
    drive(3'd1, 8'h5A);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL unf_push obs=%h exp=%h", o, e); end
    drive(3'd3, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {err, err_code, tos, count} !== {1'b1, 2'd2, 8'h5A, 4'd1}) begin
      errors++; $display("FAIL unf_binop obs=%h exp=%h", o, e);
    end
  endtask

  task automatic test_unop_not();
    obs_t o, e;
    do_reset();
    alu_mode = 2;
    drive(3'd1, 8'hF0);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL unop_push obs=%h exp=%h", o, e); end
    drive(3'd4, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {tos, count} !== {8'h0F, 4'd1}) begin
      errors++; $display("FAIL unop_not obs=%h exp=%h", o, e);
    end
    drive(3'd0, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {err, err_code} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL unop_nop obs=%h exp=%h", o, e);
    end
  endtask

  task automatic test_full_binop();
    obs_t o, e;
    do_reset();
    alu_mode = 0;
    for (int i = 1; i <= 8; i++) drive(3'd1, 8'(i));
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL fbin_fill obs=%h exp=%h", o, e); end
    drive(3'd3, 8'h00);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {tos, count, full} !== {8'h0F, 4'd7, 1'b0}) begin
      errors++; $display("FAIL fbin_add obs=%h exp=%h", o, e);
    end
    drive(3'd1, 8'h20);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e || {full, tos} !== {1'b1, 8'h20}) begin
      errors++; $display("FAIL fbin_refill obs=%h exp=%h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [2:0] c;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      alu_mode = $urandom_range(0, 2);
      // Bias toward pushes so the stack visits both empty and full.
      c = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      drive(c, 8'($urandom));
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_%0d cmd=%0d obs=%h exp=%h", i, c, o, e); end
      checks++;
      if (alu_b !== tos) begin errors++; $display("FAIL b2b_alub_%0d alu_b=%h tos=%h", i, alu_b, tos); end
    end
  endtask

  initial begin
    test_reset();
    test_binop_sub();
    test_overflow();
    test_underflow();
    test_unop_not();
    test_full_binop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
